// File: rtl/lane_queue_sensor.sv
// Lane queue sensor: counts vehicles waiting at a signalised lane.
// The raw loop detector is synchronised and debounced; each accepted rising
// level is one arrival. While the light is GREEN one vehicle departs every
// DEPART_CYCLES cycles. The queue saturates at MAX_Q and records a dropped
// arrival in a sticky overflow flag.
module lane_queue_sensor #(
   parameter int DEBOUNCE      = 3,
   parameter int DEPART_CYCLES = 4,
   parameter int MAX_Q         = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       car_in,
   input  logic [1:0] light,
   output logic       sensor_1th,
   output logic       sensor_5th,
   output logic [3:0] queue_cnt,
   output logic       car_out,
   output logic       overflow
);

   typedef enum logic [1:0] {
      LIGHT_RED    = 2'b00,
      LIGHT_YELLOW = 2'b01,
      LIGHT_GREEN  = 2'b10,
      LIGHT_BAD    = 2'b11
   } light_e;

   localparam logic [3:0] DB_TC  = 4'(DEBOUNCE);
   localparam logic [3:0] DEP_TC = 4'(DEPART_CYCLES);
   localparam logic [3:0] Q_MAX  = 4'(MAX_Q);

   logic       s1_q, s2_q;
   logic       acc_q, acc_d;
   logic [3:0] db_cnt_q, db_cnt_d;
   logic [3:0] dep_cnt_q, dep_cnt_d;
   logic [3:0] queue_q, queue_d;
   logic       car_out_q, car_out_d;
   logic       ovf_q, ovf_d;
   logic       arrival;
   logic       depart;
   logic       green;

   assign green = (light == LIGHT_GREEN);

   // Two-flop synchroniser for the asynchronous detector level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= car_in;
         s2_q <= s1_q;
      end
   end

   // Debounce: accept a new level once it has held for DEBOUNCE cycles;
   // only the 0->1 acceptance counts as an arrival.
   always_comb begin
      acc_d    = acc_q;
      db_cnt_d = 4'd0;
      arrival  = 1'b0;
      if (s2_q != acc_q) begin
         if (db_cnt_q + 4'd1 == DB_TC) begin
            acc_d   = ~acc_q;
            arrival = ~acc_q;
         end else begin
            db_cnt_d = db_cnt_q + 4'd1;
         end
      end
   end

   // Depart timer: runs only on GREEN with vehicles waiting, so the queue
   // can never be decremented below zero.
   always_comb begin
      dep_cnt_d = 4'd0;
      depart    = 1'b0;
      if (green && (queue_q != 4'd0)) begin
         if (dep_cnt_q + 4'd1 == DEP_TC) begin
            depart = 1'b1;
         end else begin
            dep_cnt_d = dep_cnt_q + 4'd1;
         end
      end
   end

   // Queue update: simultaneous arrival and departure cancel out; an arrival
   // into a full queue is dropped and flagged.
   always_comb begin
      queue_d   = queue_q;
      ovf_d     = ovf_q;
      car_out_d = depart;
      case ({arrival, depart})
         2'b10: begin
            if (queue_q == Q_MAX) begin
               ovf_d = 1'b1;
            end else begin
               queue_d = queue_q + 4'd1;
            end
         end
         2'b01:   queue_d = queue_q - 4'd1;
         default: queue_d = queue_q;
      endcase
   end

   // State registers for debounce, timer, queue and flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q     <= 1'b0;
         db_cnt_q  <= 4'd0;
         dep_cnt_q <= 4'd0;
         queue_q   <= 4'd0;
         car_out_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         db_cnt_q  <= db_cnt_d;
         dep_cnt_q <= dep_cnt_d;
         queue_q   <= queue_d;
         car_out_q <= car_out_d;
         ovf_q     <= ovf_d;
      end
   end

   assign queue_cnt  = queue_q;
   assign sensor_1th = (queue_q != 4'd0);
   assign sensor_5th = (queue_q >= 4'd5);
   assign car_out    = car_out_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_lane_queue_sensor.sv
// Directed bench for lane_queue_sensor at default parameters.
module tb_lane_queue_sensor;

   logic       clk = 1'b0;
   logic       rst;
   logic       car_in;
   logic [1:0] light;
   logic       sensor_1th;
   logic       sensor_5th;
   logic [3:0] queue_cnt;
   logic       car_out;
   logic       overflow;

   int passed = 0;
   int total  = 0;
   int pulses = 0;
   int p0;

   localparam logic [1:0] RED   = 2'b00;
   localparam logic [1:0] GREEN = 2'b10;

   lane_queue_sensor dut (
      .clk        (clk),
      .rst        (rst),
      .car_in     (car_in),
      .light      (light),
      .sensor_1th (sensor_1th),
      .sensor_5th (sensor_5th),
      .queue_cnt  (queue_cnt),
      .car_out    (car_out),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   // Count car_out pulses, sampled mid-cycle.
   always @(negedge clk) if (car_out === 1'b1) pulses++;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic arrive();
      car_in = 1'b1;
      tick(6);
      car_in = 1'b0;
      tick(6);
   endtask

   initial begin
      rst    = 1'b1;
      car_in = 1'b0;
      light  = RED;
      #2;
      check("rst_q", int'(queue_cnt), 0);
      check("rst_s1", int'(sensor_1th), 0);
      check("rst_carout", int'(car_out), 0);
      check("rst_ovf", int'(overflow), 0);
      tick(2);
      rst = 1'b0;

      // First arrival after reset: increments on the 5th edge.
      car_in = 1'b1;
      tick(4);
      check("lat_before", int'(queue_cnt), 0);
      tick(1);
      check("lat_at", int'(queue_cnt), 1);
      tick(1);
      car_in = 1'b0;
      tick(6);
      arrive();
      arrive();
      check("red3_q", int'(queue_cnt), 3);
      check("red3_s1", int'(sensor_1th), 1);
      check("red3_s5", int'(sensor_5th), 0);
      check("red3_pulses", pulses, 0);

      // Glitch shorter than the debounce window.
      car_in = 1'b1;
      tick(2);
      car_in = 1'b0;
      tick(8);
      check("short_q", int'(queue_cnt), 3);

      // Departures from 6.
      arrive();
      arrive();
      arrive();
      check("six_q", int'(queue_cnt), 6);
      check("six_s5", int'(sensor_5th), 1);
      p0 = pulses;
      light = GREEN;
      tick(3);
      check("g3_carout", int'(car_out), 0);
      check("g3_q", int'(queue_cnt), 6);
      tick(1);
      check("g4_carout", int'(car_out), 1);
      check("g4_q", int'(queue_cnt), 5);
      check("g4_s5", int'(sensor_5th), 1);
      tick(1);
      check("g5_carout", int'(car_out), 0);
      tick(2);
      check("g7_s5", int'(sensor_5th), 1);
      check("g7_q", int'(queue_cnt), 5);
      tick(1);
      check("g8_q", int'(queue_cnt), 4);
      check("g8_carout", int'(car_out), 1);
      check("g8_s5", int'(sensor_5th), 0);
      light = RED;
      tick(2);
      check("green_pulses", pulses - p0, 2);

      // Arrival and departure on the same edge at queue 5.
      arrive();
      check("sim_pre_q", int'(queue_cnt), 5);
      car_in = 1'b1;
      tick(1);
      light = GREEN;
      tick(3);
      check("sim_before_q", int'(queue_cnt), 5);
      tick(1);
      check("sim_q", int'(queue_cnt), 5);
      check("sim_carout", int'(car_out), 1);
      check("sim_s5", int'(sensor_5th), 1);
      light = RED;
      tick(1);
      check("sim_carout_end", int'(car_out), 0);
      check("sim_q_end", int'(queue_cnt), 5);
      car_in = 1'b0;
      tick(6);

      // Saturation and sticky overflow.
      repeat (10) arrive();
      check("full_q", int'(queue_cnt), 15);
      check("full_ovf", int'(overflow), 0);
      arrive();
      check("ovf_q", int'(queue_cnt), 15);
      check("ovf_set", int'(overflow), 1);
      light = GREEN;
      tick(64);
      check("drain_q", int'(queue_cnt), 0);
      check("drain_s1", int'(sensor_1th), 0);
      check("drain_ovf", int'(overflow), 1);
      light = RED;

      // Asynchronous reset mid-operation while car_out is high.
      repeat (7) arrive();
      check("seven_q", int'(queue_cnt), 7);
      light = GREEN;
      tick(4);
      check("pre_rst_carout", int'(car_out), 1);
      check("pre_rst_q", int'(queue_cnt), 6);
      #1;
      rst = 1'b1;
      #1;
      check("arst_q", int'(queue_cnt), 0);
      check("arst_carout", int'(car_out), 0);
      check("arst_s1", int'(sensor_1th), 0);
      check("arst_s5", int'(sensor_5th), 0);
      check("arst_ovf", int'(overflow), 0);
      tick(2);
      rst = 1'b0;
      p0 = pulses;
      tick(8);
      check("post_rst_pulses", pulses - p0, 0);
      check("post_rst_q", int'(queue_cnt), 0);
      light = RED;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/lane_queue_sensor.md
LANE_QUEUE_SENSOR -- requirements
Module: lane_queue_sensor

Interface
REQ-001 Parameter DEBOUNCE, default 3: consecutive synchronized cycles car_in must hold a new level before it is accepted (range 1..15).
REQ-002 Parameter DEPART_CYCLES, default 4: green cycles per vehicle departure (range 1..15).
REQ-003 Parameter MAX_Q, default 15: queue saturation depth (range 5..15).
REQ-004 Port clk, input, 1: single system clock; all state is updated on the rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port car_in, input, 1: raw vehicle detector level, asynchronous to clk; high while a vehicle is over the loop.
REQ-007 Port light, input, 2: controller light state; 2'b00 RED, 2'b01 YELLOW, 2'b10 GREEN, 2'b11 invalid.
REQ-008 Port sensor_1th, output, 1: high when queue_cnt >= 1.
REQ-009 Port sensor_5th, output, 1: high when queue_cnt >= 5.
REQ-010 Port queue_cnt, output, 4: current vehicle queue depth.
REQ-011 Port car_out, output, 1: one-cycle pulse per departed vehicle.
REQ-012 Port overflow, output, 1: sticky flag for an arrival dropped at full queue.

Function
REQ-013 car_in SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-014 Debounce: a counter SHALL increment each cycle s2 differs from the accepted level, and SHALL clear whenever s2 equals it.
REQ-015 When the counter reaches DEBOUNCE, the accepted level SHALL toggle and the counter SHALL clear in the same edge.
REQ-016 An arrival event SHALL occur on the edge where the accepted level toggles 0->1; the 1->0 toggle generates no event.
REQ-017 Latency: car_in high before edge N and held steady SHALL increment queue_cnt at edge N+1+DEBOUNCE (edge N+4 at default).
REQ-018 Pulses on s2 shorter than DEBOUNCE cycles SHALL be ignored.
REQ-019 Depart timer: SHALL increment each cycle light==GREEN and queue_cnt>0; otherwise it SHALL clear to 0.
REQ-020 When the timer would reach DEPART_CYCLES, a departure event SHALL occur: car_out=1 for that cycle, queue_cnt decrements, timer clears.
REQ-021 YELLOW, RED and 2'b11 SHALL produce no departures and SHALL clear the timer.
REQ-022 Arrival and departure in the same cycle: queue_cnt unchanged, car_out still pulses.
REQ-023 Arrival at queue_cnt==MAX_Q without a simultaneous departure: queue_cnt holds MAX_Q and overflow sets.
REQ-024 overflow SHALL stay set until rst.
REQ-025 queue_cnt SHALL never underflow, because departures require queue_cnt>0.
REQ-026 sensor_1th and sensor_5th SHALL be pure decodes of the queue_cnt register (same-cycle, glitch-free, no extra latency).
REQ-027 car_out SHALL be registered and asserted in the cycle following the edge on which queue_cnt decrements.

Reset
REQ-028 rst=1 SHALL immediately clear queue_cnt, sensor_1th, sensor_5th, car_out, overflow, the synchronizer, debounce counter, accepted level and depart timer, independent of clk.
REQ-029 Reset asserted mid-operation SHALL discard any pending arrival or departure.
REQ-030 The first arrival after reset release SHALL obey the full REQ-017 latency.

Verification
REQ-031 Test vectors:
- rst pulse with queue_cnt=7 and light GREEN -> all outputs 0 within the same cycle; no car_out after release.
- light RED, three clean car_in pulses (each high 6 cycles, low 6 cycles) -> queue_cnt=3, sensor_1th=1, sensor_5th=0, car_out never asserted.
- car_in high for 2 cycles only (DEBOUNCE=3) -> queue_cnt unchanged.
- queue_cnt=6, light GREEN for 8 cycles -> car_out pulses after the 4th and 8th green cycle; queue_cnt 6->5->4; sensor_5th falls at the second departure.
- light RED, 16 clean arrivals -> queue_cnt=15, overflow=1, still 1 after light GREEN drains the queue to 0.
- queue_cnt=5, arrival accepted on the same edge as a departure -> queue_cnt stays 5, car_out=1 for one cycle, sensor_5th stays 1.
